fpadd_mult: RTL and testbench



---
 rtl/fpadd_pkg.sv | 32 +++
 rtl/fp_lzc_norm.sv | 20 ++
 rtl/fpadd_mult.sv | 115 +++++++++++
 tb/tb_fpadd_mult.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared field widths, special encodings and unpack helper for the single-precision adder.
package fpadd_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned BIAS   = 127;
  // Working mantissa: carry + hidden + 23 fraction + guard/round/sticky.
  localparam int unsigned EXT_W  = 28;
  localparam int unsigned LZC_W  = 5;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F800000;
  localparam logic [WORD_W-1:0] NEG_INF = 32'hFF800000;

  // Unpacked operand; mant carries the hidden bit (zero for flushed inputs).
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
  } fp_unpacked_t;

  // Split a word into fields, flushing exponent-0 inputs to signed zero.
  function automatic fp_unpacked_t fp_unpack(input logic [WORD_W-1:0] w);
    fp_unpacked_t u;
    u.sign = w[WORD_W-1];
    u.exp  = w[WORD_W-2:MAN_W];
    u.mant = (w[WORD_W-2:MAN_W] == '0) ? '0 : {1'b1, w[MAN_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc_norm.sv
// Leading-zero count and left-shift normalizer for the 28-bit working mantissa.
module fp_lzc_norm
  import fpadd_pkg::*;
(
  input  logic [EXT_W-1:0] mant_in,
  output logic [EXT_W-1:0] mant_c,
  output logic [LZC_W-1:0] shift_c
);

  // Highest set bit wins because the scan runs upward; all-zero yields EXT_W.
  always_comb begin
    shift_c = LZC_W'(EXT_W);
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (mant_in[i]) shift_c = LZC_W'(int'(EXT_W) - 1 - i);
    end
  end

  assign mant_c = mant_in << shift_c;

endmodule

// File: rtl/fpadd_mult.sv
// Two-stage pipelined IEEE-754 single-precision adder, round-to-nearest-even, flush-to-zero.
module fpadd_mult
  import fpadd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] reg_A,
  input  logic [WORD_W-1:0] reg_B,
  output logic [WORD_W-1:0] result
);

  localparam int          EXP_MAX   = 2 * int'(BIAS) + 1;
  localparam logic [EXP_W-1:0] FAR_SHIFT = EXP_W'(26);
  localparam int unsigned ALN_W     = EXT_W - 1;

  logic [WORD_W-1:0] a_q, b_q, sum_c;

  fp_unpacked_t ua, ub, ux, uy;
  logic         a_nan, b_nan, a_inf, b_inf;
  logic         a_ge_b, eff_sub;
  logic [EXP_W-1:0] exp_diff;

  logic [ALN_W-1:0] y_full, y_shr, y_mask, y_al;
  logic             y_sticky;
  logic [EXT_W-1:0] x_ext, y_ext, raw, norm;
  logic [LZC_W-1:0] lz;

  logic             guard, rnd, sticky, round_up, rnd_carry;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] frac;
  int               exp_n;

  // Stage 1: capture operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= reg_A;
      b_q <= reg_B;
    end
  end

  // Stage 2: capture the rounded sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result <= '0;
    else        result <= sum_c;
  end

  assign ua    = fp_unpack(a_q);
  assign ub    = fp_unpack(b_q);
  assign a_inf = (&a_q[WORD_W-2:MAN_W]) && (a_q[MAN_W-1:0] == '0);
  assign b_inf = (&b_q[WORD_W-2:MAN_W]) && (b_q[MAN_W-1:0] == '0);
  assign a_nan = (&a_q[WORD_W-2:MAN_W]) && (a_q[MAN_W-1:0] != '0);
  assign b_nan = (&b_q[WORD_W-2:MAN_W]) && (b_q[MAN_W-1:0] != '0);

  // Larger magnitude becomes X; ties keep A as X.
  assign a_ge_b   = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
  assign ux       = a_ge_b ? ua : ub;
  assign uy       = a_ge_b ? ub : ua;
  assign exp_diff = ux.exp - uy.exp;
  assign eff_sub  = ux.sign ^ uy.sign;

  // Align Y, folding every bit shifted past the round position into sticky.
  assign y_full   = {uy.mant, 3'b000};
  assign y_shr    = y_full >> exp_diff;
  assign y_mask   = ~({ALN_W{1'b1}} << exp_diff);
  assign y_sticky = |(y_full & y_mask);
  assign y_al     = (exp_diff >= FAR_SHIFT) ? {{(ALN_W-1){1'b0}}, |uy.mant}
                                            : (y_shr | {{(ALN_W-1){1'b0}}, y_sticky});

  assign x_ext = {1'b0, ux.mant, 3'b000};
  assign y_ext = {1'b0, y_al};
  assign raw   = eff_sub ? (x_ext - y_ext) : (x_ext + y_ext);

  // Normalizes both the add carry case (shift 0) and subtract cancellation.
  fp_lzc_norm u_norm (
    .mant_in (raw),
    .mant_c  (norm),
    .shift_c (lz)
  );

  // Round to nearest, ties to even, on the normalized mantissa.
  assign guard     = norm[3];
  assign rnd       = norm[2];
  assign sticky    = |norm[1:0];
  assign round_up  = guard & (rnd | sticky | norm[4]);
  assign rounded   = {1'b0, norm[EXT_W-1:4]} + (MAN_W+2)'(round_up);
  assign rnd_carry = rounded[MAN_W+1];
  assign frac      = rnd_carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
  assign exp_n     = int'(ux.exp) + 1 - int'(lz) + int'(rnd_carry);

  // Special-case priority, then overflow/underflow, then the packed normal result.
  always_comb begin
    sum_c = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[WORD_W-1] != b_q[WORD_W-1]))) begin
      sum_c = QNAN;
    end else if (a_inf) begin
      sum_c = a_q;
    end else if (b_inf) begin
      sum_c = b_q;
    end else if ((ua.mant == '0) && (ub.mant == '0)) begin
      sum_c = {ua.sign & ub.sign, {(WORD_W-1){1'b0}}};
    end else if (raw == '0) begin
      sum_c = '0;
    end else if (exp_n >= EXP_MAX) begin
      sum_c = ux.sign ? NEG_INF : POS_INF;
    end else if (exp_n <= 0) begin
      sum_c = {ux.sign, {(WORD_W-1){1'b0}}};
    end else begin
      sum_c = {ux.sign, EXP_W'(exp_n), frac};
    end
  end

endmodule

// File: tb/tb_fpadd_mult.sv
// Directed self-checking bench for the pipelined single-precision adder.
module tb_fpadd_mult;

  localparam int NV = 16;
  localparam int NP = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reg_A, reg_B;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl [NV];
  logic [31:0] pa [NP];
  logic [31:0] pb [NP];
  logic [31:0] pe [NP];

  fpadd_mult dut (
    .clk    (clk),
    .reset  (reset),
    .reg_A  (reg_A),
    .reg_B  (reg_B),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: result=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, "rnd_tie_even"};
    tbl[1]  = '{32'h3F800000, 32'h33C00000, 32'h3F800001, "rnd_up"};
    tbl[2]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, "rnd_tie_odd"};
    tbl[3]  = '{32'h40400000, 32'hBFC00000, 32'h3FC00000, "sub_norm"};
    tbl[4]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, "cancel"};
    tbl[5]  = '{32'h3F800001, 32'hBF800000, 32'h34000000, "sub_lzc"};
    tbl[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "exp_ovf"};
    tbl[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf"};
    tbl[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, "nan_in"};
    tbl[9]  = '{32'h00000001, 32'h3F800000, 32'h3F800000, "denorm_in"};
    tbl[10] = '{32'h3FFFFFFF, 32'h33800000, 32'h40000000, "rnd_carry"};
    tbl[11] = '{32'h7F7FFFFF, 32'h73000000, 32'h7F800000, "rnd_ovf"};
    tbl[12] = '{32'h00800000, 32'h80800001, 32'h80000000, "underflow"};
    tbl[13] = '{32'h80000000, 32'h80000000, 32'h80000000, "neg_zeros"};
    tbl[14] = '{32'h80000000, 32'h00000000, 32'h00000000, "mixed_zeros"};
    tbl[15] = '{32'h3F800000, 32'hC0000000, 32'hBF800000, "swap_neg"};

    pa[0]  = 32'h3F800000; pb[0]  = 32'h3F800000; pe[0]  = 32'h40000000;
    pa[1]  = 32'h3FC00000; pb[1]  = 32'h40100000; pe[1]  = 32'h40700000;
    pa[2]  = 32'h40400000; pb[2]  = 32'hBFC00000; pe[2]  = 32'h3FC00000;
    pa[3]  = 32'h3F800000; pb[3]  = 32'hBF800000; pe[3]  = 32'h00000000;
    pa[4]  = 32'h3F800001; pb[4]  = 32'hBF800000; pe[4]  = 32'h34000000;
    pa[5]  = 32'h3F800000; pb[5]  = 32'h33C00000; pe[5]  = 32'h3F800001;
    pa[6]  = 32'h7F7FFFFF; pb[6]  = 32'h7F7FFFFF; pe[6]  = 32'h7F800000;
    pa[7]  = 32'h41200000; pb[7]  = 32'hC1A00000; pe[7]  = 32'hC1200000;
    pa[8]  = 32'h80000000; pb[8]  = 32'h80000000; pe[8]  = 32'h80000000;
    pa[9]  = 32'h80000000; pb[9]  = 32'h00000000; pe[9]  = 32'h00000000;
    pa[10] = 32'hFF800000; pb[10] = 32'h3F800000; pe[10] = 32'hFF800000;

    // Reset held: result stays zero across clock edges.
    reset = 1'b0;
    reg_A = 32'h3F800000;
    reg_B = 32'h3F800000;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_hold", result, 32'h00000000);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("reset_edge1", result, 32'h00000000);
    @(posedge clk); #1;
    check("reset_edge2", result, 32'h40000000);

    // Latency: new sum appears on the second edge, not the first.
    @(negedge clk); reg_A = 32'h00000000; reg_B = 32'h00000000;
    repeat (2) @(posedge clk); #1;
    check("zero_prime", result, 32'h00000000);
    @(negedge clk); reg_A = 32'h3FC00000; reg_B = 32'h40100000;
    @(posedge clk); #1;
    check("lat_edge1", result, 32'h00000000);
    @(posedge clk); #1;
    check("lat_edge2", result, 32'h40700000);

    // Directed table, one operation at a time.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk); reg_A = tbl[i].a; reg_B = tbl[i].b;
      repeat (2) @(posedge clk); #1;
      check(tbl[i].name, result, tbl[i].exp);
    end
    @(posedge clk); #1;
    check("hold_const", result, tbl[NV-1].exp);

    // Back-to-back: a new pair every cycle, result two edges later.
    @(negedge clk);
    for (int c = 0; c <= NP; c++) begin
      if (c < NP) begin
        reg_A = pa[c];
        reg_B = pb[c];
      end
      @(posedge clk); #1;
      if (c >= 1) check($sformatf("pipe_%0d", c - 1), result, pe[c - 1]);
    end

    // Reset mid-flight clears the pipeline asynchronously and drops in-flight work.
    @(negedge clk); reg_A = 32'h3F800000; reg_B = 32'h3F800000;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_async", result, 32'h00000000);
    @(negedge clk); reg_A = 32'h41200000; reg_B = 32'h41200000; reset = 1'b1;
    @(posedge clk); #1;
    check("rst_flush", result, 32'h00000000);
    @(posedge clk); #1;
    check("rst_resume", result, 32'h41A00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
